seq_divider: RTL and testbench

- Sequential restoring divider. It is the inverse-direction companion to the team's adder/shift-add multiplier datapath.
- Accepts an unsigned WIDTH-bit dividend and divisor on a start pulse.
- Produces quotient and remainder after WIDTH iteration cycles, one subtract-and-shift per cycle.
- Sits beside the sequential multiplier in the arithmetic unit and shares its start/done handshake style.

---
 rtl/seq_arith_pkg.sv | 12 +
 rtl/seq_divider_if.sv | 30 +++
 rtl/seq_divider_div_sub_step.sv | 20 ++
 rtl/seq_divider.sv | 140 ++++++++++++++
 tb/tb_seq_divider.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/seq_arith_pkg.sv
// Shared definitions for the sequential arithmetic unit (shift-add multiplier and restoring divider).
package seq_arith_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } arith_state_e;

endpackage

// File: rtl/seq_divider_if.sv
// Start/done bus between a requester and the sequential divider.
interface seq_divider_if
  import seq_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  // start is accepted on a rising clk edge where start && ready; operands are captured on
  // that edge only. done pulses for one cycle when quotient/remainder/div_by_zero become
  // valid, and those stay held until the next accepted start.
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  ready, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_div_sub_step.sv
// One restoring-division trial subtract: shifted partial remainder minus divisor.
module div_sub_step
  import seq_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   shifted,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] diff;

  // Subtraction as an add of the inverted, zero-extended divisor with carry-in 1.
  assign diff     = shifted + {1'b1, ~divisor} + {{WIDTH{1'b0}}, 1'b1};
  assign q_bit    = ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one subtract-and-shift per cycle, WIDTH iterations.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands (truncating division).
module seq_divider
  import seq_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus,
  output arith_state_e dbg_state
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  arith_state_e     state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] rem_r;
  logic             dbz_r;
  logic             done_r;
  logic             ready_r;

  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] q_next;
  logic             q_bit;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  div_sub_step #(.WIDTH(WIDTH)) u_step (
    .shifted  ({p, q[WIDTH-1]}),
    .divisor  (dvs),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign q_next = {q[WIDTH-2:0], q_bit};

`ifdef SEQ_DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  // Iterate on magnitudes; the most-negative value's magnitude fits as an unsigned pattern.
  assign dividend_mag = bus.dividend[WIDTH-1] ? ~bus.dividend + WIDTH'(1) : bus.dividend;
  assign divisor_mag  = bus.divisor[WIDTH-1]  ? ~bus.divisor  + WIDTH'(1) : bus.divisor;
  assign quo_fix      = neg_q ? ~q_next   + WIDTH'(1) : q_next;
  assign rem_fix      = neg_r ? ~rem_next + WIDTH'(1) : rem_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      neg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      neg_r <= bus.dividend[WIDTH-1];
    end
  end
`else
  assign dividend_mag = bus.dividend;
  assign divisor_mag  = bus.divisor;
  assign quo_fix      = q_next;
  assign rem_fix      = rem_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      p       <= '0;
      q       <= '0;
      dvs     <= '0;
      quo_r   <= '0;
      rem_r   <= '0;
      dbz_r   <= 1'b0;
      done_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            ready_r <= 1'b0;
            p       <= '0;
            q       <= dividend_mag;
            dvs     <= divisor_mag;
            if (bus.divisor == '0) begin
              state  <= FIN;
              cnt    <= '0;
              done_r <= 1'b1;
              quo_r  <= '1;
              rem_r  <= bus.dividend;
              dbz_r  <= 1'b1;
            end else begin
              state <= CALC;
              cnt   <= CNT_W'(WIDTH);
              quo_r <= '0;
              rem_r <= '0;
              dbz_r <= 1'b0;
            end
          end
        end
        CALC: begin
          p   <= rem_next;
          q   <= q_next;
          cnt <= cnt - CNT_W'(1);
          // Results land with the last step so they are valid in the FIN cycle with done.
          if (cnt == CNT_W'(1)) begin
            state  <= FIN;
            done_r <= 1'b1;
            quo_r  <= quo_fix;
            rem_r  <= rem_fix;
          end
        end
        FIN: begin
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          state   <= IDLE;
          done_r  <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready       = ready_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quo_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;
  assign dbg_state       = state;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed cases plus random operands against an arithmetic model.
module tb_seq_divider;
  import seq_arith_pkg::*;

  localparam int W  = DEFAULT_WIDTH;
  localparam int RW = 2 * W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  seq_divider_if #(.WIDTH(W)) bus ();
  arith_state_e dbg_state;

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  int errors = 0;
  int checks = 0;
  logic [RW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  bit            ready_due = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [RW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] qq;
    logic [W-1:0] rr;
`ifdef SEQ_DIV_SIGNED_EN
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == '0) return {{W{1'b1}}, a, 1'b1};
    if (sa == -(1 << (W - 1)) && sb == -1) return {a, {W{1'b0}}, 1'b0};
    qq = W'(sa / sb);
    rr = W'(sa % sb);
    return {qq, rr, 1'b0};
`else
    if (b == '0) return {{W{1'b1}}, a, 1'b1};
    qq = a / b;
    rr = a % b;
    return {qq, rr, 1'b0};
`endif
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [RW-1:0] e;
    int            c;
    if (ready_due && !rst) begin
      ready_due = 1'b0;
      check("ready_after_done", 32'(bus.ready), 32'd1);
      check("done_one_cycle", 32'(bus.done), 32'd0);
    end
    if (!rst && bus.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(bus.done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        check("result_q_r_dbz", 32'({bus.quotient, bus.remainder, bus.div_by_zero}), 32'(e));
        check("done_cycle", 32'(cyc), 32'(c));
        check("ready_low_with_done", 32'(bus.ready), 32'd0);
        ready_due = 1'b1;
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [RW-1:0] exp, input bit push);
    int n = 0;
    while (!bus.ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(bus.ready), 32'd1);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    if (push) begin
      exp_q.push_back(exp);
      exp_cyc_q.push_back(cyc + 1 + ((b == '0) ? 0 : W));
    end
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor  = W'($urandom);
    check("ready_busy", 32'(bus.ready), 32'd0);
    if (b != '0)
      check("cleared_on_start", 32'({bus.quotient, bus.remainder, bus.div_by_zero}), 32'd0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || !bus.ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst          = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_ready", 32'(bus.ready), 32'd1);
    check("reset_outputs", 32'({bus.done, bus.quotient, bus.remainder, bus.div_by_zero}), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    issue(4'd13, 4'd4, {4'd3, 4'd1, 1'b0}, 1'b1);
    wait_drain();

    issue(4'd15, 4'd1, {4'd15, 4'd0, 1'b0}, 1'b1);
    issue(4'd3, 4'd9, {4'd0, 4'd3, 1'b0}, 1'b1);
    wait_drain();

    issue(4'd7, 4'd0, {4'hF, 4'd7, 1'b1}, 1'b1);
    issue(4'd10, 4'd3, {4'd3, 4'd1, 1'b0}, 1'b1);
    wait_drain();

    // A second start during CALC must be ignored.
    issue(4'd12, 4'd5, {4'd2, 4'd2, 1'b0}, 1'b1);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 4'd9;
    bus.divisor  = 4'd2;
    @(negedge clk);
    bus.start    = 1'b0;
    wait_drain();

    // Reset in cycle 3 aborts the operation.
    issue(4'd14, 4'd3, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_outputs", 32'({bus.done, bus.quotient, bus.remainder, bus.div_by_zero}), 32'd0);
    repeat (W + 4) @(negedge clk);

`ifdef SEQ_DIV_SIGNED_EN
    issue(4'b1001, 4'b0010, {4'b1101, 4'b1111, 1'b0}, 1'b1);
    issue(4'b1000, 4'b1111, {4'b1000, 4'b0000, 1'b0}, 1'b1);
    wait_drain();
`endif

    for (int i = 0; i < 40; i++) begin
      a = W'($urandom_range(0, (1 << W) - 1));
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, (1 << W) - 1));
      issue(a, b, model(a, b), 1'b1);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    wait_drain();
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
